// File: rtl/vga_pix_if.sv
// Pixel-fetch channel between the raster controller (master) and a pipelined
// pixel source (slave): coordinates go out, coverage and colour come back.
interface vga_pix_if #(
  parameter int COORD_W = 12,
  parameter int COLOR_W = 8
);
  logic [COORD_W-1:0]   pix_x;
  logic [COORD_W-1:0]   pix_y;
  logic                 pix_req;
  logic                 pix_valid;
  logic [3*COLOR_W-1:0] pix_color;

  modport master (output pix_x, pix_y, pix_req, input pix_valid, pix_color);
  modport slave  (input pix_x, pix_y, pix_req, output pix_valid, pix_color);
endinterface

// File: rtl/vga_raster_ctrl.sv
// Parametrised VGA raster controller: clock-enable pixel timing, look-ahead pixel
// fetch, and a sync-aligned output stage with background-colour substitution.
module vga_raster_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int PIX_LAT  = 2,
  parameter int COLOR_W  = 8,
  parameter int COORD_W  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [3*COLOR_W-1:0] bg_color,
  vga_pix_if.master            pix,
  output logic                 pix_ce,
  output logic                 hsync_out,
  output logic                 vsync_out,
  output logic [COLOR_W-1:0]   o_red,
  output logic [COLOR_W-1:0]   o_green,
  output logic [COLOR_W-1:0]   o_blue,
  output logic                 in_display,
  output logic                 line_start,
  output logic                 frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEG   = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] VS_BEG   = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic sol;
    logic sof;
  } flags_t;

  logic               idle;
  logic [DIV_W-1:0]   div_cnt, div_nxt;
  logic [COORD_W-1:0] h, v, h_nxt, v_nxt;
  flags_t             cur, tap;

  assign idle = rst || !enable;

  always_comb begin
    div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    h_nxt   = h;
    v_nxt   = v;
    if (pix_ce) begin
      if (h == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h_nxt = h + 1'b1;
      end
    end
  end

  // pix_req is computed from the next counter values so that it is already valid
  // in the very first pix_ce cycle after enable, which presents (0,0).
  // NOTE: sequential state uses non-blocking assignments and a synchronous reset
  // folded together with enable, so idle and reset are the same restart point.
  always_ff @(posedge clk) begin
    if (idle) begin
      div_cnt     <= '0;
      pix_ce      <= 1'b0;
      h           <= '0;
      v           <= '0;
      pix.pix_req <= 1'b0;
    end else begin
      div_cnt     <= div_nxt;
      pix_ce      <= (div_nxt == DIV_LAST);
      h           <= h_nxt;
      v           <= v_nxt;
      pix.pix_req <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
    end
  end

  assign pix.pix_x = h;
  assign pix.pix_y = v;

  always_comb begin
    cur.de  = (h < H_ACT) && (v < V_ACT);
    cur.hs  = (h >= HS_BEG) && (h < HS_END);
    cur.vs  = (v >= VS_BEG) && (v < VS_END);
    cur.sol = (h == '0);
    cur.sof = (h == '0) && (v == '0);
  end

  generate
    if (PIX_LAT == 0) begin : g_no_dly
      assign tap = cur;
    end else begin : g_dly
      flags_t pipe [PIX_LAT];
      // NOTE: the delay line is cleared on restart; a stale sync or de bit left in
      // it would otherwise reach the pins during the first PIX_LAT ticks.
      always_ff @(posedge clk) begin
        if (idle) begin
          for (int i = 0; i < PIX_LAT; i++) pipe[i] <= '0;
        end else if (pix_ce) begin
          pipe[0] <= cur;
          for (int i = 1; i < PIX_LAT; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign tap = pipe[PIX_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (idle) begin
      {o_red, o_green, o_blue} <= '0;
      in_display               <= 1'b0;
      hsync_out                <= ~HS_POL;
      vsync_out                <= ~VS_POL;
      line_start               <= 1'b0;
      frame_start              <= 1'b0;
    end else if (pix_ce) begin
      {o_red, o_green, o_blue} <= tap.de ? (pix.pix_valid ? pix.pix_color : bg_color) : '0;
      in_display               <= tap.de;
      hsync_out                <= tap.hs ? HS_POL : ~HS_POL;
      vsync_out                <= tap.vs ? VS_POL : ~VS_POL;
      line_start               <= tap.sol;
      frame_start              <= tap.sof;
    end
  end
endmodule

// File: tb/tb_vga_raster_ctrl.sv
// Self-checking bench: default 640x480 timing with a latency-2 pixel source, and a
// tiny 8x5 raster with CLK_DIV=1, PIX_LAT=0 for full-frame wrap checks.
module tb_vga_raster_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic enable_a = 1'b1;
  logic enable_b = 1'b0;
  logic src_mode = 1'b0;
  logic [23:0] bg_a = 24'h0;
  logic [23:0] bg_b = 24'hFFFFFF;

  logic pix_ce_a, hs_a, vs_a, de_a, ls_a, fs_a;
  logic [7:0] r_a, g_a, b_a;
  logic pix_ce_b, hs_b, vs_b, de_b, ls_b, fs_b;
  logic [7:0] r_b, g_b, b_b;

  vga_pix_if #(.COORD_W(12), .COLOR_W(8)) pix_a ();
  vga_pix_if #(.COORD_W(4),  .COLOR_W(8)) pix_b ();

  vga_raster_ctrl dut_a (
    .clk(clk), .rst(rst), .enable(enable_a), .bg_color(bg_a), .pix(pix_a),
    .pix_ce(pix_ce_a), .hsync_out(hs_a), .vsync_out(vs_a),
    .o_red(r_a), .o_green(g_a), .o_blue(b_a),
    .in_display(de_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_raster_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .PIX_LAT(0), .COLOR_W(8), .COORD_W(4)
  ) dut_b (
    .clk(clk), .rst(rst), .enable(enable_b), .bg_color(bg_b), .pix(pix_b),
    .pix_ce(pix_ce_b), .hsync_out(hs_b), .vsync_out(vs_b),
    .o_red(r_b), .o_green(g_b), .o_blue(b_b),
    .in_display(de_b), .line_start(ls_b), .frame_start(fs_b)
  );

  logic [28:0] pins_a, pins_b;
  assign pins_a = {r_a, g_a, b_a, hs_a, vs_a, de_a, ls_a, fs_a};
  assign pins_b = {r_b, g_b, b_b, hs_b, vs_b, de_b, ls_b, fs_b};

  // Zero-latency source for the small raster: always covers, colour encodes (x,y).
  assign pix_b.pix_valid = 1'b1;
  assign pix_b.pix_color = {4'h0, pix_b.pix_x, 4'h0, pix_b.pix_y, 8'hC3};

  // Latency-2 source for the default raster; garbage is driven between ticks.
  typedef struct packed {
    logic        req;
    logic [11:0] x;
    logic [11:0] y;
  } req_t;
  req_t hist [3];

  always @(negedge clk) begin
    if (rst || !enable_a) begin
      for (int i = 0; i < 3; i++) hist[i] = '0;
      pix_a.pix_valid = 1'b0;
      pix_a.pix_color = 24'h0;
    end else if (pix_ce_a) begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = {pix_a.pix_req, pix_a.pix_x, pix_a.pix_y};
      pix_a.pix_valid = !src_mode && hist[2].req;
      pix_a.pix_color = {hist[2].x[7:0], hist[2].y[7:0], 8'h5A};
      bg_a = src_mode ? 24'h0096FF : 24'h123456;
    end else begin
      pix_a.pix_valid = 1'($urandom);
      pix_a.pix_color = 24'($urandom);
      bg_a = 24'($urandom);
    end
  end

  typedef struct {
    int         phase;
    int         x;
    int         y;
    logic [23:0] rgb;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  int n_cmp = 0;
  int n_bad = 0;
  int tick = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pix_ce_a && n < 16);
    if (!pix_ce_a) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tick_timeout: no pix_ce within %0d clk", n);
    end
    tick++;
  endtask

  task automatic wait_fetch(input int x, input int y);
    int n = 0;
    while (!(pix_a.pix_x == 12'(x) && pix_a.pix_y == 12'(y)) && n < 8000) begin
      next_tick();
      n++;
    end
    check($sformatf("reach_fetch_%0d_%0d", x, y),
          32'(pix_a.pix_x == 12'(x) && pix_a.pix_y == 12'(y)), 32'd1);
  endtask

  // Pins show the coordinate fetched PIX_LAT+1 = 3 ticks earlier.
  task automatic run_vectors(input int phase);
    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].phase == phase) begin
        int target = vecs[i].y * 800 + vecs[i].x;
        int guard = 0;
        while (tick - 3 < target && guard < 4000) begin
          next_tick();
          guard++;
        end
        check($sformatf("vec%0d_(%0d,%0d)", i, vecs[i].x, vecs[i].y), 32'(pins_a),
              32'({vecs[i].rgb, vecs[i].hs, vecs[i].vs, vecs[i].de, vecs[i].ls, vecs[i].fs}));
      end
    end
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_pins"}, 32'(pins_a), 32'({24'h0, 1'b1, 1'b1, 3'b000}));
    check({tag, "_fetch"}, 32'({pix_ce_a, pix_a.pix_req, pix_a.pix_x, pix_a.pix_y}), 32'd0);
  endtask

  task automatic check_restart_a(input string tag);
    check({tag, "_first_ce"}, 32'({pix_ce_a, pix_a.pix_req, pix_a.pix_x, pix_a.pix_y}),
          32'({1'b1, 1'b1, 12'd0, 12'd0}));
    tick = 0;
    for (int i = 1; i <= 3; i++) begin
      next_tick();
      check($sformatf("%s_fs_tick%0d", tag, i), 32'(fs_a), 32'(i == 3));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_lo, vs_lo, de_hi, ls_hi;
    int fx, fy, o, h, v;
    logic de;
    logic [7:0] hs_pat;
    logic [4:0] vs_pat;
    hs_pat = 8'b1001_1111;
    vs_pat = 5'b10111;

    vecs[0]  = '{0,   0, 0, 24'h00005A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{0,   1, 0, 24'h01005A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{0, 255, 0, 24'hFF005A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{0, 256, 0, 24'h00005A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{0, 639, 0, 24'h7F005A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{0, 640, 0, 24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{0, 655, 0, 24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{0, 656, 0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{0, 751, 0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{0, 752, 0, 24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{0, 799, 0, 24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{0,   0, 1, 24'h00015A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{0, 300, 1, 24'h2C015A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{0, 639, 1, 24'h7F015A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1,   1, 0, 24'h0096FF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1, 639, 0, 24'h0096FF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1, 640, 0, 24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1, 700, 0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1,   0, 1, 24'h0096FF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset held for 3 clk with enable high.
    repeat (3) @(negedge clk);
    check_idle_a("reset");
    rst = 1'b0;
    @(negedge clk);
    tick = 0;
    check("first_ce_fetch", 32'({pix_ce_a, pix_a.pix_req, pix_a.pix_x, pix_a.pix_y}),
          32'({1'b1, 1'b1, 12'd0, 12'd0}));

    run_vectors(0);

    // One full line period of raw clk cycles inside the active lines.
    hs_lo = 0; vs_lo = 0; de_hi = 0; ls_hi = 0;
    for (int i = 0; i < 1600; i++) begin
      @(negedge clk);
      if (pix_ce_a) tick++;
      hs_lo += int'(!hs_a);
      vs_lo += int'(!vs_a);
      de_hi += int'(de_a);
      ls_hi += int'(ls_a);
    end
    check("line_hsync_low_clk", 32'(hs_lo), 32'd192);
    check("line_vsync_low_clk", 32'(vs_lo), 32'd0);
    check("line_display_clk", 32'(de_hi), 32'd1280);
    check("line_start_clk", 32'(ls_hi), 32'd2);

    // Enable dropped mid-line for 5 clk, then restart in background mode.
    wait_fetch(300, 3);
    enable_a = 1'b0;
    @(negedge clk);
    check_idle_a("en_drop");
    repeat (4) @(negedge clk);
    check_idle_a("en_hold");
    src_mode = 1'b1;
    enable_a = 1'b1;
    @(negedge clk);
    check_restart_a("en_rise");
    check("en_rise_first_pixel", 32'(pins_a), 32'({24'h0096FF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}));
    run_vectors(1);

    // Reset pulse mid-line while enable stays high.
    wait_fetch(100, 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_a("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    check_restart_a("rst_rise");
    check("rst_rise_first_pixel", 32'(pins_a), 32'({24'h0096FF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}));
    enable_a = 1'b0;

    // Tiny raster: every clk is a tick, pins lag fetch by exactly one tick.
    enable_b = 1'b1;
    for (int t = 0; t < 90; t++) begin
      @(negedge clk);
      check($sformatf("b_ce_t%0d", t), 32'(pix_ce_b), 32'd1);
      fx = t % 8;
      fy = (t / 8) % 5;
      check($sformatf("b_fetch_t%0d", t), 32'({pix_b.pix_req, pix_b.pix_x, pix_b.pix_y}),
            32'({fx < 4 && fy < 2, 4'(fx), 4'(fy)}));
      if (t >= 1) begin
        o  = t - 1;
        h  = o % 8;
        v  = (o / 8) % 5;
        de = (h < 4) && (v < 2);
        check($sformatf("b_pins_t%0d", t), 32'(pins_b),
              32'({de ? {4'h0, 4'(h), 4'h0, 4'(v), 8'hC3} : 24'h0,
                   hs_pat[h], vs_pat[v], de, h == 0, h == 0 && v == 0}));
      end
    end
    enable_b = 1'b0;
    @(negedge clk);
    check("b_disable", 32'({pix_ce_b, pins_b}), 32'({1'b0, 24'h0, 1'b1, 1'b1, 3'b000}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
